// File: rtl/sumador_serie.sv
// Bit-serial adder/subtractor: one full-adder cell processes one bit per clock, LSB first.
// The result, carry-out and signed overflow are registered and only change on completion.
module sumador_serie #(
  parameter int unsigned ANCHO = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inicio,
  input  logic             i_resta,
  input  logic [ANCHO-1:0] i_operando_a,
  input  logic [ANCHO-1:0] i_operando_b,
  input  logic             i_acarreo,
  output logic             o_ocupado,
  output logic             o_listo,
  output logic [ANCHO-1:0] o_suma,
  output logic             o_acarreo,
  output logic             o_desborde
);

  localparam int unsigned CW = (ANCHO > 1) ? $clog2(ANCHO) : 1;

  typedef enum logic [1:0] {Reposo, Sumando, Listo} estado_e;

  estado_e          estado_q, estado_d;
  logic [ANCHO-1:0] a_q, a_d;
  logic [ANCHO-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cuenta_q, cuenta_d;
  logic [ANCHO-1:0] res_q, res_d;
  logic [ANCHO-1:0] suma_q, suma_d;
  logic             acarreo_q, acarreo_d;
  logic             desborde_q, desborde_d;
  logic             ocupado_q, ocupado_d;
  logic             listo_q, listo_d;

  logic s_bit;
  logic c_sig;

  always_comb begin
    s_bit = a_q[0] ^ b_q[0] ^ c_q;
    c_sig = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));

    estado_d   = estado_q;
    a_d        = a_q;
    b_d        = b_q;
    c_d        = c_q;
    cuenta_d   = cuenta_q;
    res_d      = res_q;
    suma_d     = suma_q;
    acarreo_d  = acarreo_q;
    desborde_d = desborde_q;
    ocupado_d  = 1'b0;
    listo_d    = 1'b0;

    unique case (estado_q)
      Reposo: begin
        if (i_inicio) begin
          a_d       = i_operando_a;
          // Subtraction is A + ~B + 1; carry-in is ignored in that mode.
          b_d       = i_resta ? ~i_operando_b : i_operando_b;
          c_d       = i_resta | i_acarreo;
          cuenta_d  = '0;
          estado_d  = Sumando;
          ocupado_d = 1'b1;
        end
      end
      Sumando: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        c_d      = c_sig;
        res_d    = {s_bit, res_q[ANCHO-1:1]};
        cuenta_d = cuenta_q + CW'(1);
        if (cuenta_q == CW'(ANCHO - 1)) begin
          estado_d   = Listo;
          listo_d    = 1'b1;
          suma_d     = {s_bit, res_q[ANCHO-1:1]};
          acarreo_d  = c_sig;
          // Overflow: carry into the MSB differs from carry out of it.
          desborde_d = c_q ^ c_sig;
        end else begin
          ocupado_d = 1'b1;
        end
      end
      Listo: begin
        estado_d = Reposo;
      end
      default: begin
        estado_d = Reposo;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      estado_q   <= Reposo;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= 1'b0;
      cuenta_q   <= '0;
      res_q      <= '0;
      suma_q     <= '0;
      acarreo_q  <= 1'b0;
      desborde_q <= 1'b0;
      ocupado_q  <= 1'b0;
      listo_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      a_q        <= a_d;
      b_q        <= b_d;
      c_q        <= c_d;
      cuenta_q   <= cuenta_d;
      res_q      <= res_d;
      suma_q     <= suma_d;
      acarreo_q  <= acarreo_d;
      desborde_q <= desborde_d;
      ocupado_q  <= ocupado_d;
      listo_q    <= listo_d;
    end
  end

  assign o_ocupado  = ocupado_q;
  assign o_listo    = listo_q;
  assign o_suma     = suma_q;
  assign o_acarreo  = acarreo_q;
  assign o_desborde = desborde_q;

endmodule

// File: tb/tb_sumador_serie.sv
// Scoreboard bench for sumador_serie (ANCHO=4): expected results come from integer arithmetic
// and are queued at issue; a monitor compares them whenever o_listo pulses.
module tb_sumador_serie;
  localparam int unsigned ANCHO = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_inicio = 1'b0;
  logic             i_resta = 1'b0;
  logic [ANCHO-1:0] i_operando_a = '0;
  logic [ANCHO-1:0] i_operando_b = '0;
  logic             i_acarreo = 1'b0;
  logic             o_ocupado;
  logic             o_listo;
  logic [ANCHO-1:0] o_suma;
  logic             o_acarreo;
  logic             o_desborde;

  sumador_serie #(.ANCHO(ANCHO)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_inicio     (i_inicio),
    .i_resta      (i_resta),
    .i_operando_a (i_operando_a),
    .i_operando_b (i_operando_b),
    .i_acarreo    (i_acarreo),
    .o_ocupado    (o_ocupado),
    .o_listo      (o_listo),
    .o_suma       (o_suma),
    .o_acarreo    (o_acarreo),
    .o_desborde   (o_desborde)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ANCHO-1:0] suma;
    logic             c;
    logic             v;
  } esp_t;

  esp_t cola[$];
  int   checks = 0;
  int   errors = 0;
  esp_t prev = '0;

  task automatic chk(input string nombre, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nombre, act, exp);
    end
  endtask

  // Reference: plain unsigned/signed integer arithmetic on the operands.
  function automatic esp_t modelo(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b,
                                  input logic cin, input logic resta);
    esp_t r;
    int ua, ub, sa, sb, full, sfull;
    ua = int'(a);
    ub = int'(b);
    sa = a[ANCHO-1] ? ua - (1 << ANCHO) : ua;
    sb = b[ANCHO-1] ? ub - (1 << ANCHO) : ub;
    if (!resta) begin
      full  = ua + ub + int'(cin);
      sfull = sa + sb + int'(cin);
      r.c   = (full >= (1 << ANCHO));
    end else begin
      full  = ua - ub;
      sfull = sa - sb;
      r.c   = (ua >= ub);
    end
    r.suma = full[ANCHO-1:0];
    r.v    = (sfull > (1 << (ANCHO - 1)) - 1) || (sfull < -(1 << (ANCHO - 1)));
    return r;
  endfunction

  always @(negedge clk) begin
    esp_t e;
    if (!rst && o_listo) begin
      if (cola.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL listo_inesperado: got o_listo=1 expected 0 (no pending op)");
      end else begin
        e = cola.pop_front();
        chk("suma", 64'(o_suma), 64'(e.suma));
        chk("acarreo", 64'(o_acarreo), 64'(e.c));
        chk("desborde", 64'(o_desborde), 64'(e.v));
      end
    end
  end

  task automatic run_op(input logic [ANCHO-1:0] a, input logic [ANCHO-1:0] b,
                        input logic cin, input logic resta, input logic molestar);
    esp_t e;
    int   edges, busy;
    logic hold_ok;
    @(negedge clk);
    i_inicio     = 1'b1;
    i_resta      = resta;
    i_operando_a = a;
    i_operando_b = b;
    i_acarreo    = cin;
    e = modelo(a, b, cin, resta);
    cola.push_back(e);
    @(posedge clk);
    @(negedge clk);
    i_inicio     = 1'b0;
    // Operand changes after the accept edge must not leak into the result.
    i_operando_a = ANCHO'($urandom);
    i_operando_b = ANCHO'($urandom);
    i_acarreo    = 1'($urandom);
    i_resta      = 1'($urandom);
    edges   = 0;
    busy    = 0;
    hold_ok = 1'b1;
    while (!o_listo && edges < 3 * ANCHO) begin
      if (o_ocupado) busy++;
      if (o_suma !== prev.suma || o_acarreo !== prev.c || o_desborde !== prev.v) hold_ok = 1'b0;
      i_inicio = molestar && (edges == 1);
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("latencia", 64'(edges), 64'(ANCHO));
    chk("ciclos_ocupado", 64'(busy), 64'(ANCHO));
    chk("retencion", 64'(hold_ok), 64'd1);
    chk("ocupado_en_listo", 64'(o_ocupado), 64'd0);
    i_inicio = molestar;
    @(posedge clk);
    @(negedge clk);
    i_inicio = 1'b0;
    chk("vuelta_reposo", 64'({o_listo, o_ocupado}), 64'd0);
    prev = e;
  endtask

  function automatic logic [63:0] salidas();
    return 64'({o_ocupado, o_listo, o_suma, o_acarreo, o_desborde});
  endfunction

  initial begin
    int   espera;
    logic visto;
    #3;
    chk("reset_inicial", salidas(), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(4'hF, 4'h1, 1'b0, 1'b0, 1'b0);
    run_op(4'h7, 4'h1, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges clears outputs with no clock.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("reset_asincrono", salidas(), 64'd0);
    prev = '0;
    @(negedge clk);
    rst = 1'b0;

    run_op(4'h3, 4'h5, 1'b0, 1'b1, 1'b0);
    run_op(4'h8, 4'h1, 1'b1, 1'b1, 1'b0);
    run_op(4'h2, 4'h3, 1'b0, 1'b0, 1'b1);

    // Reset while bit 2 is being processed: abort, no o_listo.
    @(negedge clk);
    i_inicio     = 1'b1;
    i_resta      = 1'b0;
    i_operando_a = 4'h6;
    i_operando_b = 4'h7;
    i_acarreo    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    i_inicio = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("reset_mitad", salidas(), 64'd0);
    prev = '0;
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    visto = 1'b0;
    repeat (2 * ANCHO) begin
      @(negedge clk);
      if (o_listo) visto = 1'b1;
    end
    chk("sin_listo_tras_abortar", 64'(visto), 64'd0);

    run_op(4'hA, 4'h5, 1'b0, 1'b0, 1'b0);

    repeat (40) begin
      run_op(ANCHO'($urandom), ANCHO'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom_range(0, 3) == 0));
    end

    espera = 0;
    while (cola.size() != 0 && espera < 20) begin
      @(negedge clk);
      espera++;
    end
    chk("cola_vacia", 64'(cola.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sumador_serie.md
SUMADOR_SERIE -- requirements
Module: sumador_serie

Interface
REQ-001 The block SHALL have parameter: ANCHO, 8, operand and result width in bits (legal range 2..64).
REQ-002 The block SHALL have port: i_clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port: i_rst  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port: i_inicio  input  1  start request, sampled on rising edge.
REQ-005 The block SHALL have port: i_resta  input  1  mode select (0 = A+B+cin, 1 = A-B), sampled with i_inicio.
REQ-006 The block SHALL have port: i_operando_a  input  ANCHO  operand A, sampled with i_inicio.
REQ-007 The block SHALL have port: i_operando_b  input  ANCHO  operand B, sampled with i_inicio.
REQ-008 The block SHALL have port: i_acarreo  input  1  carry-in for addition, sampled with i_inicio, ignored when i_resta=1.
REQ-009 The block SHALL have port: o_ocupado  output  1  high while bits are being processed.
REQ-010 The block SHALL have port: o_listo  output  1  one-cycle pulse, result valid.
REQ-011 The block SHALL have port: o_suma  output  ANCHO  registered result.
REQ-012 The block SHALL have port: o_acarreo  output  1  registered carry-out (in subtraction: 1 = no borrow).
REQ-013 The block SHALL have port: o_desborde  output  1  registered two's-complement signed overflow flag.

Function
REQ-014 The block SHALL implement a bit-serial adder: one full-adder cell, LSB first, one bit per clock, with a registered carry between bits.
REQ-015 The FSM SHALL have three states: REPOSO, SUMANDO, LISTO.
REQ-016 In REPOSO with i_inicio=1, the block SHALL capture the operands, mode and carry-in, clear the bit counter, and go to SUMANDO on that edge (the accept edge).
REQ-017 In subtraction mode, the block SHALL capture ~i_operando_b and force the initial carry to 1.
REQ-018 In SUMANDO, each edge SHALL shift A and B right by one, process one bit, shift the sum bit into an internal result register from the MSB end, and increment the counter.
REQ-019 On the edge that processes bit ANCHO-1, the block SHALL go to LISTO and load o_suma, o_acarreo (final carry) and o_desborde (carry into MSB XOR carry out of MSB).
REQ-020 Latency: o_listo SHALL rise exactly ANCHO edges after the accept edge.
REQ-021 o_listo SHALL be high for exactly one cycle; LISTO SHALL go to REPOSO unconditionally on the next edge.
REQ-022 o_ocupado SHALL be 1 only in SUMANDO; o_listo SHALL be 1 only in LISTO.
REQ-023 o_suma, o_acarreo and o_desborde SHALL hold their previous values during SUMANDO and until the next LISTO; intermediate bits SHALL NOT be visible on them.
REQ-024 i_inicio SHALL be ignored in SUMANDO and LISTO, with no queuing; changes on the operand inputs after the accept edge SHALL NOT affect the result.
REQ-025 Arithmetic SHALL be modulo 2^ANCHO; no width extension or saturation.

Reset
REQ-026 Asserting i_rst SHALL immediately, without a clock, force the FSM to REPOSO and clear the counter, the internal registers and all outputs (o_ocupado=0, o_listo=0, o_suma=0, o_acarreo=0, o_desborde=0).
REQ-027 Reset asserted mid-operation SHALL abort the operation with no o_listo pulse.
REQ-028 The first i_inicio SHALL be accepted on the first rising edge after i_rst deasserts.

Verification (ANCHO=4)
REQ-029 The bench SHALL cover: assert i_rst asynchronously between edges -> all outputs 0 immediately.
REQ-030 The bench SHALL cover: A=4'hF, B=4'h1, cin=0, add -> o_suma=4'h0, o_acarreo=1, o_desborde=0, with o_listo exactly 4 edges after accept and o_ocupado high for 4 cycles.
REQ-031 The bench SHALL cover: A=4'h7, B=4'h1, cin=1, add -> o_suma=4'h9, o_acarreo=0, o_desborde=1.
REQ-032 The bench SHALL cover: A=4'h3, B=4'h5, subtract -> o_suma=4'hE, o_acarreo=0, o_desborde=0; and A=4'h8, B=4'h1, subtract -> o_suma=4'h7, o_acarreo=1, o_desborde=1.
REQ-033 The bench SHALL cover: i_inicio pulsed with new operands during SUMANDO and during LISTO -> ignored, first result unchanged, FSM returns to REPOSO.
REQ-034 The bench SHALL cover: i_rst asserted at bit 2 of an operation -> no o_listo, outputs 0; then a new operation completes correctly.
